ir_queue: RTL and testbench



---
 rtl/ir_queue_pkg.sv | 17 +
 rtl/ir_queue_fields.sv | 29 ++
 rtl/ir_queue.sv | 102 ++++++++++
 tb/tb_ir_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ir_queue_pkg.sv
// LC-3b shared types: instruction word, decoded field types and the queue entry.
package ir_queue_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [4:0]  lc3b_imm5;
  typedef logic [10:0] lc3b_imm11;

  typedef struct packed {
    lc3b_word word;
    lc3b_word pc;
  } lc3b_ir_entry;

endpackage

// File: rtl/ir_queue_fields.sv
// ir_fields slicer: purely combinational split of an LC-3b word into decode fields.
module ir_queue_fields
  import ir_queue_pkg::*;
(
  input  lc3b_word    word,
  output lc3b_opcode  opcode,
  output lc3b_reg     dest,
  output lc3b_reg     src1,
  output lc3b_reg     src2,
  output lc3b_offset6 offset6,
  output lc3b_offset9 offset9,
  output lc3b_imm5    imm5,
  output lc3b_imm11   imm11,
  output logic        imm5_enable,
  output logic        imm11_enable
);

  assign opcode       = word[15:12];
  assign dest         = word[11:9];
  assign src1         = word[8:6];
  assign src2         = word[2:0];
  assign offset6      = word[5:0];
  assign offset9      = word[8:0];
  assign imm5         = word[4:0];
  assign imm11        = word[10:0];
  assign imm5_enable  = word[5];
  assign imm11_enable = word[11];

endmodule

// File: rtl/ir_queue.sv
// Instruction FIFO of {word, pc} with decoded head fields; 1-cycle push-to-head latency.
// Optional IR_QUEUE_BYPASS_EN forwards a push into an empty queue to the head in the same cycle.
module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         in,
  input  logic [PC_WIDTH-1:0]      pc_in,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [PC_WIDTH-1:0]      pc_out,
  output lc3b_opcode               opcode,
  output lc3b_reg                  dest,
  output lc3b_reg                  src1,
  output lc3b_reg                  src2,
  output lc3b_offset6              offset6,
  output lc3b_offset9              offset9,
  output lc3b_imm5                 imm5,
  output lc3b_imm11                imm11,
  output logic                     imm5_enable,
  output logic                     imm11_enable
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]    word_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [AW:0]         cnt;

  logic empty, full, do_push, bypass, store_push, take_pop;
  logic [WIDTH-1:0]    head_word;

  assign empty      = (cnt == '0);
  assign full       = (cnt == FULL_CNT);
  assign push_ready = !full;
  assign do_push    = push_valid && !full;
  assign count      = cnt;

`ifdef IR_QUEUE_BYPASS_EN
  assign bypass = empty && do_push && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that is popped in the same cycle never lands in storage.
  assign store_push = do_push && !(bypass && pop);
  assign take_pop   = pop && !empty;
  assign head_valid = !empty || bypass;

  assign head_word = bypass ? in    : word_mem[rd_ptr];
  assign pc_out    = bypass ? pc_in : pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store_push) wr_ptr <= wr_ptr + AW'(1);
      if (take_pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({store_push, take_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is intentionally not reset; only pointers and occupancy are.
  always_ff @(posedge clk) begin
    if (!reset && !flush && store_push) begin
      word_mem[wr_ptr] <= in;
      pc_mem[wr_ptr]   <= pc_in;
    end
  end

  ir_queue_fields u_fields (
    .word         (head_word[15:0]),
    .opcode       (opcode),
    .dest         (dest),
    .src1         (src1),
    .src2         (src2),
    .offset6      (offset6),
    .offset9      (offset9),
    .imm5         (imm5),
    .imm11        (imm11),
    .imm5_enable  (imm5_enable),
    .imm11_enable (imm11_enable)
  );

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: queue-based reference model checked every cycle plus literal checks.
module tb_ir_queue;
  import ir_queue_pkg::*;

  localparam int DEPTH = 4;

`ifdef IR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [15:0] in = '0;
  logic [15:0] pc_in = '0;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic        head_valid;
  logic [2:0]  count;
  logic [15:0] pc_out;
  lc3b_opcode  opcode;
  lc3b_reg     dest, src1, src2;
  lc3b_offset6 offset6;
  lc3b_offset9 offset9;
  lc3b_imm5    imm5;
  lc3b_imm11   imm11;
  logic        imm5_enable, imm11_enable;

  ir_queue #(.DEPTH(DEPTH), .WIDTH(16), .PC_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
    .in(in), .pc_in(pc_in), .pop(pop), .flush(flush), .head_valid(head_valid),
    .count(count), .pc_out(pc_out), .opcode(opcode), .dest(dest), .src1(src1),
    .src2(src2), .offset6(offset6), .offset9(offset9), .imm5(imm5), .imm11(imm11),
    .imm5_enable(imm5_enable), .imm11_enable(imm11_enable)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {word, pc}.
  typedef struct { logic [15:0] w; logic [15:0] pc; } ent_t;
  ent_t q[$];

  function automatic bit model_bypass();
    return BYP && q.size() == 0 && push_valid && !flush && !reset;
  endfunction

  always @(posedge clk) begin
    bit can_push;
    ent_t e;
    if (reset || flush) begin
      q.delete();
    end else begin
      can_push = push_valid && (q.size() < DEPTH);
      e.w = in;
      e.pc = pc_in;
      if (model_bypass() && pop) begin
        // word consumed on the fly, nothing retained
      end else begin
        if (pop && q.size() > 0) void'(q.pop_front());
        if (can_push) q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    ent_t h;
    bit hv;
    if (model_on && !reset) begin
      hv = (q.size() > 0) || model_bypass();
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_push_ready", 32'(push_ready), 32'(q.size() < DEPTH));
      chk("m_head_valid", 32'(head_valid), 32'(hv));
      if (hv) begin
        if (q.size() > 0) h = q[0];
        else begin h.w = in; h.pc = pc_in; end
        chk("m_pc_out", 32'(pc_out), 32'(h.pc));
        chk("m_fields_a", {opcode, dest, src1, src2, offset6, imm5_enable, imm11_enable},
            {h.w[15:12], h.w[11:9], h.w[8:6], h.w[2:0], h.w[5:0], h.w[5], h.w[11]});
        chk("m_fields_b", {offset9, imm5, imm11}, {h.w[8:0], h.w[4:0], h.w[10:0]});
      end
    end
  end

  // Drive inputs for one cycle, applied just after a rising edge.
  task automatic cyc(input logic pv, input logic [15:0] w, input logic [15:0] pc,
                     input logic pp, input logic fl);
    @(posedge clk);
    #1;
    push_valid = pv; in = w; pc_in = pc; pop = pp; flush = fl;
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; push_valid = 1'b0; pop = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [15:0] wtab [4];

  initial begin
    wtab[0] = 16'h1283; wtab[1] = 16'h5A3F; wtab[2] = 16'h6E85; wtab[3] = 16'hC1C0;

    do_reset();
    model_on = 1'b1;
    #1;
    chk("rst_head_valid", 32'(head_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);

    // ADD R1,R2,#-3
    cyc(1'b1, 16'h12BD, 16'h3000, 1'b0, 1'b0);
    idle(); #1;
    chk("add_head_valid", 32'(head_valid), 32'd1);
    chk("add_opcode", 32'(opcode), 32'h1);
    chk("add_dest", 32'(dest), 32'd1);
    chk("add_src1", 32'(src1), 32'd2);
    chk("add_imm5_en", 32'(imm5_enable), 32'd1);
    chk("add_imm5", 32'(imm5), 32'h1D);
    chk("add_pc", 32'(pc_out), 32'h3000);
    chk("add_count", 32'(count), 32'd1);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(); #1;
    chk("add_popped_count", 32'(count), 32'd0);

    // fill to DEPTH, then a blocked fifth push
    for (int i = 0; i < 4; i++) cyc(1'b1, wtab[i], 16'h4000 + 16'(2*i), 1'b0, 1'b0);
    cyc(1'b1, 16'hFFFF, 16'h4FFE, 1'b0, 1'b0);
    idle(); #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_push_ready", 32'(push_ready), 32'd0);
    chk("full_head_pc", 32'(pc_out), 32'h4000);

    // full: push and pop together -> only the pop happens
    cyc(1'b1, 16'hEEEE, 16'h4EEE, 1'b1, 1'b0);
    idle(); #1;
    chk("fullpp_count", 32'(count), 32'd3);
    chk("fullpp_push_ready", 32'(push_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("order_pc", 32'(pc_out), 32'h4000 + 32'(2*i));
      chk("order_opcode", 32'(opcode), 32'(wtab[i][15:12]));
      chk("order_offset9", 32'(offset9), 32'(wtab[i][8:0]));
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      idle(); #1;
    end
    chk("drained_count", 32'(count), 32'd0);

    // pop on empty is ignored
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(); #1;
    chk("empty_pop_count", 32'(count), 32'd0);

    // flush beats simultaneous push/pop
    cyc(1'b1, 16'h2222, 16'h6000, 1'b0, 1'b0);
    cyc(1'b1, 16'h3333, 16'h6002, 1'b0, 1'b0);
    idle(); #1;
    chk("preflush_count", 32'(count), 32'd2);
    cyc(1'b1, 16'h4444, 16'h6004, 1'b1, 1'b1);
    idle(); #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_head_valid", 32'(head_valid), 32'd0);
    cyc(1'b1, 16'h0E05, 16'h6100, 1'b0, 1'b0);
    idle(); #1;
    chk("postflush_opcode", 32'(opcode), 32'h0);
    chk("postflush_offset9", 32'(offset9), 32'h005);
    chk("postflush_pc", 32'(pc_out), 32'h6100);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle();

    // JSR into an empty queue: same-cycle visibility only with bypass
    cyc(1'b1, 16'h4801, 16'h5000, 1'b0, 1'b0); #1;
    chk("jsr_same_cycle_hv", 32'(head_valid), 32'(BYP));
    if (BYP) chk("jsr_same_cycle_imm11", 32'(imm11), 32'h001);
    idle(); #1;
    chk("jsr_next_hv", 32'(head_valid), 32'd1);
    chk("jsr_imm11", 32'(imm11), 32'h001);
    chk("jsr_imm11_en", 32'(imm11_enable), 32'd1);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle();

    // push+pop into an empty queue
    cyc(1'b1, 16'h9ABC, 16'h5100, 1'b1, 1'b0);
    idle(); #1;
    chk("empty_pushpop_count", 32'(count), BYP ? 32'd0 : 32'd1);
    if (!BYP) begin
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      idle();
    end

    // reset mid-operation drops everything
    cyc(1'b1, 16'h7123, 16'h7000, 1'b0, 1'b0);
    cyc(1'b1, 16'h8456, 16'h7002, 1'b0, 1'b0);
    do_reset(); #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_head_valid", 32'(head_valid), 32'd0);
    chk("midrst_push_ready", 32'(push_ready), 32'd1);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
